// File: rtl/dff_write_arbiter_pkg.sv
// Shared types for the DFF write arbiter: FSM state encoding and pointer-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } arb_state_e;

    localparam int unsigned MIN_REQ = 2;
    localparam int unsigned MAX_REQ = 8;

    // Width of an index into N requesters; never below 1 bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Requester-side bus of the DFF write arbiter (request, data, grant, ack, register view).
// Latency: n/a (wiring only).
// Backpressure: requesters hold Req/Din until Gnt; Lock only exists with DFF_ARB_LOCK_EN.
interface dff_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    import dff_arb_pkg::*;

    localparam int PW = ptr_w(N_REQ);

    logic [N_REQ-1:0]       Req;
    logic [N_REQ*WIDTH-1:0] Din;
`ifdef DFF_ARB_LOCK_EN
    logic [N_REQ-1:0]       Lock;
`endif
    logic [N_REQ-1:0]       Gnt;
    logic [N_REQ-1:0]       Ack;
    logic [PW-1:0]          Owner;
    logic                   Busy;
    logic [WIDTH-1:0]       Q;
    logic [WIDTH-1:0]       Qbar;

`ifdef DFF_ARB_LOCK_EN
    modport master (output Req, Din, Lock, input Gnt, Ack, Owner, Busy, Q, Qbar);
    modport slave  (input Req, Din, Lock, output Gnt, Ack, Owner, Busy, Q, Qbar);
`else
    modport master (output Req, Din, input Gnt, Ack, Owner, Busy, Q, Qbar);
    modport slave  (input Req, Din, output Gnt, Ack, Owner, Busy, Q, Qbar);
`endif

endinterface

// File: rtl/dff_write_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above the pointer, wrapping modulo N_REQ.
// Latency: combinational, zero cycles.
// Backpressure: none; valid_o low when no request is pending.
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    winner_o,
    output logic             valid_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan from the pointer upward; the first hit wins and later hits are ignored.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            idx = sum[PW-1:0];
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit D register (Q/Qbar); DFF_ARB_LOCK_EN adds Lock bursts.
// Latency: Req seen in IDLE -> Gnt next cycle -> Q updated and Ack the cycle after; 1 write per 2 cycles sustained.
// Backpressure: requesters hold Req/Din until Gnt and drop Req by the cycle after Ack, else they are re-arbitrated.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Clr,
    dff_write_arbiter_if.slave bus
);

    localparam int PW = ptr_w(N_REQ);

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic [WIDTH-1:0] din_arr [N_REQ];
    logic [PW-1:0]    win_inc;
    logic [PW-1:0]    pick_ptr;
    logic [PW-1:0]    pick_win;
    logic             pick_vld;
    logic             burst;

    // Unpack the flat data bus so the winner index selects a whole word.
    for (genvar i = 0; i < N_REQ; i++) begin : g_din
        assign din_arr[i] = bus.Din[i*WIDTH +: WIDTH];
    end

    assign win_inc = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    // In COMMIT the next winner is chosen with the pointer as it will be after this write.
    assign pick_ptr = (state_q == COMMIT) ? win_inc : ptr_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req_i    (bus.Req),
        .ptr_i    (pick_ptr),
        .winner_o (pick_win),
        .valid_o  (pick_vld)
    );

`ifdef DFF_ARB_LOCK_EN
    // A locked requester still requesting keeps the register for back-to-back writes.
    assign burst = (state_q == COMMIT) && bus.Lock[win_q] && bus.Req[win_q];
`else
    assign burst = 1'b0;
`endif

    // Next-state and registered-output decode; grant and ack are each one-cycle pulses.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        owner_d = owner_q;
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d         = GRANT;
                    win_d           = pick_win;
                    owner_d         = pick_win;
                    gnt_d[pick_win] = 1'b1;
                end
            end
            GRANT: begin
                // The write commits even if the requester has already dropped Req.
                q_d          = din_arr[win_q];
                ack_d[win_q] = 1'b1;
                state_d      = COMMIT;
            end
            COMMIT: begin
                if (burst) begin
                    state_d      = GRANT;
                    owner_d      = win_q;
                    gnt_d[win_q] = 1'b1;
                end else begin
                    ptr_d = win_inc;
                    if (pick_vld) begin
                        state_d         = GRANT;
                        win_d           = pick_win;
                        owner_d         = pick_win;
                        gnt_d[pick_win] = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register bank; Clr overrides everything, dropping any write in flight.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
        end
    end

    assign bus.Gnt   = gnt_q;
    assign bus.Ack   = ack_q;
    assign bus.Owner = owner_q;
    assign bus.Busy  = (state_q != IDLE);
    assign bus.Q     = q_q;
    assign bus.Qbar  = ~q_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter: reset, single write, wrap, contention, Clr mid-write, Lock bursts.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: bench drops Req once Gnt is seen, as a well-behaved requester would.
module tb_dff_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    dff_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    dff_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int i, input logic [W-1:0] v);
        bus.Din[i*W +: W] = v;
    endtask

    logic [W-1:0] cdata [N];
    int           corder [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr      = 1'b1;
        bus.Req  = '0;
        bus.Din  = '0;
`ifdef DFF_ARB_LOCK_EN
        bus.Lock = '0;
`endif
        cdata  = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        corder = '{0, 1, 2, 3, 0};

        // Reset: two cycles of Clr with no requests.
        tick();
        tick();
        chk("rst_q",     bus.Q,     32'h00);
        chk("rst_qbar",  bus.Qbar,  32'hFF);
        chk("rst_gnt",   bus.Gnt,   32'h0);
        chk("rst_ack",   bus.Ack,   32'h0);
        chk("rst_busy",  bus.Busy,  32'h0);
        chk("rst_owner", bus.Owner, 32'h0);
        clr = 1'b0;

        // Single write from requester 2.
        set_din(0, 8'h10); set_din(1, 8'h20); set_din(2, 8'hA5); set_din(3, 8'h40);
        bus.Req = 4'b0100;
        tick();
        chk("single_gnt",   bus.Gnt,   32'h4);
        chk("single_owner", bus.Owner, 32'h2);
        chk("single_busy",  bus.Busy,  32'h1);
        chk("single_ack0",  bus.Ack,   32'h0);
        bus.Req = '0;
        tick();
        chk("single_q",    bus.Q,    32'hA5);
        chk("single_qbar", bus.Qbar, 32'h5A);
        chk("single_ack",  bus.Ack,  32'h4);
        chk("single_gnt0", bus.Gnt,  32'h0);
        tick();
        chk("single_idle", bus.Busy, 32'h0);
        chk("single_hold", bus.Q,    32'hA5);

        // Wrap: pointer now 3, requesters 3 and 0 -> 3 first, then 0.
        set_din(0, 8'h11); set_din(3, 8'h33);
        bus.Req = 4'b1001;
        tick();
        chk("wrap_gnt3",   bus.Gnt,   32'h8);
        chk("wrap_owner3", bus.Owner, 32'h3);
        bus.Req = 4'b0001;
        tick();
        chk("wrap_ack3", bus.Ack, 32'h8);
        chk("wrap_q3",   bus.Q,   32'h33);
        tick();
        chk("wrap_gnt0",   bus.Gnt,   32'h1);
        chk("wrap_owner0", bus.Owner, 32'h0);
        bus.Req = '0;
        tick();
        chk("wrap_ack0", bus.Ack, 32'h1);
        chk("wrap_q0",   bus.Q,   32'h11);
        tick();
        chk("wrap_idle", bus.Busy, 32'h0);

        // Contention: re-reset so the pointer starts at 0, then all four request.
        clr = 1'b1;
        tick();
        chk("rerst_q", bus.Q, 32'h00);
        clr = 1'b0;
        for (int i = 0; i < N; i++) set_din(i, cdata[i]);
        bus.Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("cont_gnt%0d", k),   bus.Gnt,   32'(1 << corder[k]));
            chk($sformatf("cont_owner%0d", k), bus.Owner, 32'(corder[k]));
            chk($sformatf("cont_busyg%0d", k), bus.Busy,  32'h1);
            chk($sformatf("cont_ackg%0d", k),  bus.Ack,   32'h0);
            if (k == 4) bus.Req = '0;
            tick();
            chk($sformatf("cont_ack%0d", k),   bus.Ack,   32'(1 << corder[k]));
            chk($sformatf("cont_q%0d", k),     bus.Q,     32'(cdata[corder[k]]));
            chk($sformatf("cont_gntc%0d", k),  bus.Gnt,   32'h0);
            chk($sformatf("cont_busyc%0d", k), bus.Busy,  32'h1);
        end
        tick();
        chk("cont_idle", bus.Busy, 32'h0);

        // Clr while in GRANT: write discarded, no Ack.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_din(1, 8'h3C);
        bus.Req = 4'b0010;
        tick();
        chk("clrg_gnt", bus.Gnt, 32'h2);
        clr = 1'b1;
        bus.Req = '0;
        tick();
        chk("clrg_q",    bus.Q,    32'h00);
        chk("clrg_qbar", bus.Qbar, 32'hFF);
        chk("clrg_ack",  bus.Ack,  32'h0);
        chk("clrg_gnt0", bus.Gnt,  32'h0);
        chk("clrg_busy", bus.Busy, 32'h0);
        clr = 1'b0;
        tick();
        chk("clrg_ack1",  bus.Ack,  32'h0);
        chk("clrg_busy1", bus.Busy, 32'h0);
        chk("clrg_q1",    bus.Q,    32'h00);

`ifdef DFF_ARB_LOCK_EN
        // Lock burst: requester 0 keeps the register until Lock drops, then 1.
        set_din(0, 8'h71); set_din(1, 8'h72);
        bus.Req  = 4'b0011;
        bus.Lock = 4'b0001;
        tick();
        chk("lock_gnt0a", bus.Gnt, 32'h1);
        tick();
        chk("lock_ack0a", bus.Ack, 32'h1);
        chk("lock_q0a",   bus.Q,   32'h71);
        tick();
        chk("lock_gnt0b", bus.Gnt, 32'h1);
        set_din(0, 8'h7A);
        tick();
        chk("lock_ack0b", bus.Ack, 32'h1);
        chk("lock_q0b",   bus.Q,   32'h7A);
        bus.Lock = '0;
        tick();
        chk("lock_gnt1",   bus.Gnt,   32'h2);
        chk("lock_owner1", bus.Owner, 32'h1);
        bus.Req = '0;
        tick();
        chk("lock_ack1", bus.Ack, 32'h2);
        chk("lock_q1",   bus.Q,   32'h72);
        tick();
        chk("lock_idle", bus.Busy, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register (Q/Qbar) among N_REQ requesters. Each requester raises a request with its data word; the arbiter grants one requester at a time, loads that word into the shared register, and acknowledges completion. It sits in front of the team's flip-flop storage elements as their only write path.

## Interface

- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of the shared register
- Clk  input  1  clock; all state updates on rising edge
- Clr  input  1  reset; synchronous, active-high
- Req  input  N_REQ  per-requester write request, level
- Din  input  N_REQ*WIDTH  packed data; requester i uses Din[i*WIDTH +: WIDTH]
- Lock  input  N_REQ  per-requester lock hint (present only with DFF_ARB_LOCK_EN)
- Gnt  output  N_REQ  one-hot grant, registered
- Ack  output  N_REQ  one-hot write-complete pulse, registered
- Owner  output  $clog2(N_REQ)  index of last granted requester
- Busy  output  1  high whenever state is not IDLE
- Q  output  WIDTH  shared register contents
- Qbar  output  WIDTH  bitwise complement of Q, always

## Operation

- States: IDLE, GRANT, COMMIT. Encoding in shared package.
- Reset values (Clr high at an edge): state IDLE, Gnt 0, Ack 0, Owner 0, Busy 0, Q all zeros, Qbar all ones, RR pointer 0.
- IDLE: if any Req bit high, pick winner, go GRANT; else stay.
- Winner selection: first set Req bit scanning from RR pointer upward, wrapping modulo N_REQ.
- GRANT: Gnt[winner]=1 for exactly one cycle; Din slice of winner is loaded into Q at the edge leaving GRANT regardless of Req at that time. Always go COMMIT.
- COMMIT: Ack[winner]=1 for exactly one cycle; RR pointer ← (winner+1) mod N_REQ; Owner ← winner (Owner updated at entry to GRANT). If any Req high, pick new winner using updated pointer and go GRANT; else IDLE.
- Requester obligations: hold Req and Din stable until Gnt seen; drop Req by the cycle after Ack or it is re-arbitrated.
- Req dropped while in IDLE before selection: not granted. Req dropped during GRANT: write still commits.
- Only one Gnt bit and one Ack bit ever high; Gnt and Ack never high in same cycle.

## Timing

- Req rises before edge k (state IDLE) → Gnt high in cycle k+1 → Q new value and Ack high in cycle k+2.
- Write latency 2 cycles from IDLE; sustained throughput 1 write per 2 cycles (COMMIT → GRANT direct).
- Qbar is combinational from Q, zero extra latency.
- Clr mid-operation: at that edge state IDLE, Q cleared, pending write in GRANT discarded, no Ack issued.
- Clr has priority over all other events in the same cycle.

## Configuration

- DFF_ARB_LOCK_EN defined: Lock port exists. In COMMIT, if Lock[winner] and Req[winner] both high, the same requester is re-granted and RR pointer is not advanced (burst writes). Lock ignored in IDLE.
- Undefined: no Lock port; strict round-robin; pointer always advances in COMMIT.

## Structure

- Package dff_arb_pkg: state enum (IDLE, GRANT, COMMIT), localparam for pointer width helper.
- One sub-module: rr_pick (combinational, N_REQ parameter): inputs Req, pointer; outputs winner index and any-valid flag. Top holds FSM, pointer, and the register bank.

## Test plan

- Reset: Clr=1 two cycles, Req=0 → Q=8'h00, Qbar=8'hFF, Gnt=0, Ack=0, Busy=0, Owner=0.
- Single write: Req=4'b0100, Din slice2=8'hA5 → Gnt=4'b0100 next cycle, then Q=8'hA5, Qbar=8'h5A, Ack=4'b0100, Owner=2.
- Contention fairness: Req=4'b1111 held with distinct data → grant order 0,1,2,3,0, Gnt every other cycle, Busy continuously high.
- Wrap: pointer at 3, Req=4'b1001 → requester 3 granted first, then 0.
- Clr during GRANT (Din=8'h3C) → Q stays 8'h00, no Ack, state IDLE next cycle.
- DFF_ARB_LOCK_EN: Req=4'b0011, Lock=4'b0001 → requester 0 granted repeatedly until Lock drops, then requester 1.
